// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: HI/LO register pair with a 32-step radix-2 sequential
// multiply/divide engine (mult, multu, div, divu) plus mthi/mtlo writes.
//
// Handshake: start is accepted on a rising edge only while busy=0 (IDLE or
// DONE). busy stays high from the cycle after acceptance through FIX. done is
// a registered one-cycle pulse marking the cycle in which hi/lo first show the
// new result. div_by_zero is only ever high together with done.
module hilo_muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] b_q, b_d;          // multiplicand (mult) or divisor (div) magnitude
  logic [63:0] p_q, p_d;          // {accumulator/remainder, multiplier/quotient}
  logic        neg_q, neg_d;      // negate product / quotient
  logic        neg_rem_q, neg_rem_d;
  logic        dbz_flag_q, dbz_flag_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dbz_q, dbz_d;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh, diff;
  logic [63:0] div_next;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes and one iteration of each datapath.
  always_comb begin
    is_signed = ~op[0];
    abs_a     = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    abs_b     = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
    // Shift-add: add multiplicand when the multiplier LSB is set, shift right.
    mul_sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, b_q} : 33'd0);
    mul_next  = {mul_sum, p_q[31:1]};
    // Restoring divide: shift in next dividend bit, keep difference if no borrow.
    rem_sh    = {p_q[63:32], p_q[31]};
    diff      = rem_sh - {1'b0, b_q};
    if (!diff[32]) div_next = {diff[31:0], p_q[30:0], 1'b1};
    else           div_next = {rem_sh[31:0], p_q[30:0], 1'b0};
    prod_fix  = neg_q ? (~p_q + 64'd1) : p_q;
    quo_fix   = neg_q ? (~p_q[31:0] + 32'd1) : p_q[31:0];
    rem_fix   = neg_rem_q ? (~p_q[63:32] + 32'd1) : p_q[63:32];
  end

  // Next-state and register update logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    b_d        = b_q;
    p_d        = p_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dbz_flag_d = dbz_flag_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dbz_d      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          // start has priority; any simultaneous mthi/mtlo is dropped.
          op_d       = op;
          cnt_d      = 5'd0;
          if (op[1]) begin
            p_d = {32'd0, abs_a};
            b_d = abs_b;
          end else begin
            p_d = {32'd0, abs_b};
            b_d = abs_a;
          end
          neg_d      = is_signed & (op_a[31] ^ op_b[31]);
          neg_rem_d  = is_signed & op_a[31];
          dbz_flag_d = op[1] & (op_b == 32'd0);
          state_d    = S_RUN;
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_RUN: begin
        p_d   = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_q[1]) begin
          hi_d = rem_fix;
          // A zero divisor yields an all-ones quotient; remainder is op_a.
          lo_d = dbz_flag_q ? 32'hFFFF_FFFF : quo_fix;
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        dbz_d   = dbz_flag_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      cnt_q      <= 5'd0;
      b_q        <= 32'd0;
      p_q        <= 64'd0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_flag_q <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      b_q        <= b_d;
      p_q        <= p_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dbz_flag_q <= dbz_flag_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed testbench for hilo_muldiv_unit. Inputs are driven and outputs
// sampled on the falling edge; cycle 1 is the first cycle after start is taken.
module tb_hilo_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] op_a, op_b;
  logic        mthi, mtlo;
  logic [31:0] wdata;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks;
  int failures;

  hilo_muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: launch one op at the current negedge and wait (bounded) for done.
  // Leaves the caller at the negedge of the done cycle.
  task automatic drive_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt, output logic busy_at_done,
                          output int done_cyc, output logic dbz,
                          output logic [31:0] rhi, output logic [31:0] rlo);
    busy_cnt = 0; busy_at_done = 1'bx; done_cyc = -1; dbz = 1'bx; rhi = 'x; rlo = 'x;
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin
        done_cyc = cyc; busy_at_done = busy; dbz = div_by_zero; rhi = hi; rlo = lo;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 0; op = 0; op_a = 0; op_b = 0; mthi = 0; mtlo = 0; wdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero, hi, lo} !== 67'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b dbz=%b hi=%h lo=%h, required all zero",
               busy, done, div_by_zero, hi, lo);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      failures++;
      $display("FAIL reset_release: busy=%b done=%b hi=%h lo=%h, required zero", busy, done, hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678 || lo !== 32'd0) begin
      failures++;
      $display("FAIL mthi: hi=%h lo=%h, required hi=12345678 lo=00000000", hi, lo);
    end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h55AA_55AA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'h55AA_55AA || lo !== 32'h55AA_55AA) begin
      failures++;
      $display("FAIL mthi_mtlo_both: hi=%h lo=%h, required 55aa55aa/55aa55aa", hi, lo);
    end
  endtask

  task automatic test_ignore_during_run();
    int done_cyc;
    done_cyc = -1;
    start = 1'b1; op = 2'b11; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 5) begin
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF_0000;
        start = 1'b1; op = 2'b00; op_a = 32'd5; op_b = 32'd5;
      end
      if (cyc == 6) begin
        mthi = 1'b0; mtlo = 1'b0; start = 1'b0;
      end
      if (cyc == 20) begin
        checks++;
        if (hi !== 32'h55AA_55AA || lo !== 32'h55AA_55AA || busy !== 1'b1) begin
          failures++;
          $display("FAIL hold_during_run: hi=%h lo=%h busy=%b, required 55aa55aa/55aa55aa busy=1",
                   hi, lo, busy);
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (done_cyc != 34 || hi !== 32'd2 || lo !== 32'd14) begin
      failures++;
      $display("FAIL ignore_run_result: done_cyc=%0d hi=%h lo=%h, required 34 00000002 0000000e",
               done_cyc, hi, lo);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL ignored_start: busy=%b done=%b after done, required 0/0", busy, done);
    end
  endtask

  task automatic test_mult_signed();
    int bc, dc; logic bd, dz; logic [31:0] rh, rl;
    drive_op(2'b00, 32'hFFFF_FFFD, 32'd7, bc, bd, dc, dz, rh, rl);
    checks++;
    if (bc != 33 || bd !== 1'b0 || dc != 34) begin
      failures++;
      $display("FAIL mult_timing: busy_cycles=%0d busy_at_done=%b done_cyc=%0d, required 33 0 34",
               bc, bd, dc);
    end
    checks++;
    if (rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFEB || dz !== 1'b0) begin
      failures++;
      $display("FAIL mult_result: hi=%h lo=%h dbz=%b, required ffffffff ffffffeb 0", rh, rl, dz);
    end
  endtask

  task automatic test_back_to_back();
    int bc, dc; logic bd, dz; logic [31:0] rh, rl;
    drive_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, bd, dc, dz, rh, rl);
    checks++;
    if (dc != 34 || rh !== 32'hFFFF_FFFE || rl !== 32'h0000_0001) begin
      failures++;
      $display("FAIL multu_result: done_cyc=%0d hi=%h lo=%h, required 34 fffffffe 00000001", dc, rh, rl);
    end
    drive_op(2'b10, 32'hFFFF_FFF9, 32'd2, bc, bd, dc, dz, rh, rl);
    checks++;
    if (dc != 34 || bc != 33 || rh !== 32'hFFFF_FFFF || rl !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL b2b_div_result: done_cyc=%0d busy=%0d hi=%h lo=%h, required 34 33 ffffffff fffffffd",
               dc, bc, rh, rl);
    end
  endtask

  task automatic test_div_by_zero();
    int bc, dc; logic bd, dz; logic [31:0] rh, rl;
    drive_op(2'b11, 32'd7, 32'd0, bc, bd, dc, dz, rh, rl);
    checks++;
    if (dc != 34 || rh !== 32'd7 || rl !== 32'hFFFF_FFFF || dz !== 1'b1) begin
      failures++;
      $display("FAIL divu_by_zero: done_cyc=%0d hi=%h lo=%h dbz=%b, required 34 00000007 ffffffff 1",
               dc, rh, rl, dz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL dbz_pulse: done=%b dbz=%b next cycle, required 0/0", done, div_by_zero);
    end
    drive_op(2'b10, 32'hFFFF_FFF6, 32'd0, bc, bd, dc, dz, rh, rl);
    checks++;
    if (dc != 34 || rh !== 32'hFFFF_FFF6 || rl !== 32'hFFFF_FFFF || dz !== 1'b1) begin
      failures++;
      $display("FAIL div_by_zero_signed: done_cyc=%0d hi=%h lo=%h dbz=%b, required 34 fffffff6 ffffffff 1",
               dc, rh, rl, dz);
    end
  endtask

  task automatic test_div_overflow();
    int bc, dc; logic bd, dz; logic [31:0] rh, rl;
    drive_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bc, bd, dc, dz, rh, rl);
    checks++;
    if (dc != 34 || rh !== 32'd0 || rl !== 32'h8000_0000 || dz !== 1'b0) begin
      failures++;
      $display("FAIL div_overflow: done_cyc=%0d hi=%h lo=%h dbz=%b, required 34 00000000 80000000 0",
               dc, rh, rl, dz);
    end
  endtask

  task automatic test_start_with_mtlo();
    int bc, dc; logic bd, dz; logic [31:0] rh, rl;
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    drive_op(2'b01, 32'd2, 32'd3, bc, bd, dc, dz, rh, rl);
    mtlo = 1'b0;
    checks++;
    if (dc != 34 || rh !== 32'd0 || rl !== 32'd6) begin
      failures++;
      $display("FAIL start_with_mtlo: done_cyc=%0d hi=%h lo=%h, required 34 00000000 00000006", dc, rh, rl);
    end
  endtask

  task automatic test_async_reset();
    int done_seen;
    done_seen = 0;
    start = 1'b1; op = 2'b00; op_a = 32'd3; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: busy=%b hi=%h lo=%h done=%b, required 0 0 0 0", busy, hi, lo, done);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++;
    if (done_seen != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      failures++;
      $display("FAIL no_done_after_reset: done_pulses=%0d hi=%h lo=%h, required 0 0 0", done_seen, hi, lo);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_mthi_mtlo();
    test_ignore_during_run();
    test_mult_signed();
    test_back_to_back();
    test_div_by_zero();
    test_div_overflow();
    test_start_with_mtlo();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
